shift_pipe_ctrl: RTL and testbench

- Two-stage pipeline controller around the combinational 32-bit shifters (SLL, SRL, SRA) in the execute path.
- Stage 1 registers the operand, the shift amount and the op, and drives them onto the shifter inputs.
- Stage 2 selects the matching shifter result, registers it, and hands it to write-back with a valid/ready handshake.
- Adds a zero flag, a destination tag, flush and backpressure, so the shifter can sit in a pipelined datapath.

---
 rtl/shift_pipe_ctrl_if.sv | 36 +++
 rtl/shift_pipe_ctrl.sv | 109 ++++++++++
 tb/tb_shift_pipe_ctrl.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_pipe_ctrl_if.sv
// Request/result handshake bundle for the shift pipeline controller.
// The master side issues requests and consumes results; the slave side is the controller.
interface shift_pipe_ctrl_if #(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int TW = 5
);
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_op;
    logic [DW-1:0] in_data;
    logic [DW-1:0] in_rs2;
    logic [AW-1:0] in_shamt;
    logic          in_use_imm;
    logic [TW-1:0] in_tag;

    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [TW-1:0] out_tag;
    logic          out_zero;

    modport master (
        output in_valid, in_op, in_data, in_rs2, in_shamt, in_use_imm, in_tag,
        input  in_ready,
        input  out_valid, out_data, out_tag, out_zero,
        output out_ready
    );

    modport slave (
        input  in_valid, in_op, in_data, in_rs2, in_shamt, in_use_imm, in_tag,
        output in_ready,
        output out_valid, out_data, out_tag, out_zero,
        input  out_ready
    );
endinterface

// File: rtl/shift_pipe_ctrl.sv
// Two-stage pipeline controller around external SLL/SRL/SRA shifters.
// Stage 1 registers operand/amount/op/tag and feeds the shifters; stage 2
// registers the selected result with a zero flag for a valid/ready consumer.
module shift_pipe_ctrl #(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int TW = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    shift_pipe_ctrl_if.slave   bus,
    output logic [DW-1:0]      shf_in,
    output logic [AW-1:0]      shf_amt,
    input  logic [DW-1:0]      sll_res,
    input  logic [DW-1:0]      srl_res,
    input  logic [DW-1:0]      sra_res,
    output logic               busy
);

    typedef enum logic [1:0] {
        OP_SLL  = 2'b00,
        OP_SRL  = 2'b01,
        OP_SRA  = 2'b10,
        OP_PASS = 2'b11
    } op_e;

    logic          v1;
    logic          v2;
    op_e           s1_op;
    logic [TW-1:0] s1_tag;
    logic [DW-1:0] s2_data;
    logic [TW-1:0] s2_tag;
    logic          s2_zero;

    logic          s2_take;
    logic          s1_adv;
    logic          in_rdy;
    logic          accept;
    logic [AW-1:0] amt;
    logic [DW-1:0] res;

    // Upper rs2 bits are deliberately ignored: only the low AW bits form the amount.
    assign amt     = bus.in_use_imm ? bus.in_shamt : bus.in_rs2[AW-1:0];

    assign s2_take = !v2 || bus.out_ready;
    assign s1_adv  = v1 && s2_take;
    assign in_rdy  = !v1 || s2_take;
    assign accept  = bus.in_valid && in_rdy;

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = v2;
    assign bus.out_data  = s2_data;
    assign bus.out_tag   = s2_tag;
    assign bus.out_zero  = s2_zero;
    assign busy          = v1 || v2;

    // Pick the shifter output matching the op held in stage 1.
    always_comb begin
        res = shf_in;
        case (s1_op)
            OP_SLL:  res = sll_res;
            OP_SRL:  res = srl_res;
            OP_SRA:  res = sra_res;
            default: res = shf_in;
        endcase
    end

    // Stage 1: capture an accepted request, or empty when its op moves on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1      <= 1'b0;
            shf_in  <= '0;
            shf_amt <= '0;
            s1_op   <= OP_SLL;
            s1_tag  <= '0;
        end else if (flush) begin
            v1 <= 1'b0;
        end else if (accept) begin
            v1      <= 1'b1;
            shf_in  <= bus.in_data;
            shf_amt <= amt;
            s1_op   <= op_e'(bus.in_op);
            s1_tag  <= bus.in_tag;
        end else if (s1_adv) begin
            v1 <= 1'b0;
        end
    end

    // Stage 2: register the selected result; hold it while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2      <= 1'b0;
            s2_data <= '0;
            s2_tag  <= '0;
            s2_zero <= 1'b0;
        end else if (flush) begin
            v2 <= 1'b0;
        end else if (s1_adv) begin
            v2      <= 1'b1;
            s2_data <= res;
            s2_tag  <= s1_tag;
            s2_zero <= (res == '0);
        end else if (bus.out_ready) begin
            v2 <= 1'b0;
        end
    end

endmodule

// File: tb/tb_shift_pipe_ctrl.sv
// Self-checking bench for shift_pipe_ctrl: directed cases plus randomized
// traffic compared against a queue-based model of the pipeline.
module tb_shift_pipe_ctrl;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [31:0] shf_in;
    logic [4:0]  shf_amt;
    logic [31:0] sll_res;
    logic [31:0] srl_res;
    logic [31:0] sra_res;
    logic        busy;

    int checks = 0;
    int errors = 0;

    shift_pipe_ctrl_if #(.DW(32), .AW(5), .TW(5)) bus ();

    shift_pipe_ctrl #(.DW(32), .AW(5), .TW(5)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .bus     (bus),
        .shf_in  (shf_in),
        .shf_amt (shf_amt),
        .sll_res (sll_res),
        .srl_res (srl_res),
        .sra_res (sra_res),
        .busy    (busy)
    );

    // Combinational shifters sitting in the execute path.
    assign sll_res = shf_in << shf_amt;
    assign srl_res = shf_in >> shf_amt;
    assign sra_res = 32'($signed(shf_in) >>> shf_amt);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: ops in flight in order; vis marks an op that is on the output.
    typedef struct {
        logic [31:0] d;
        logic [4:0]  t;
        bit          vis;
    } ent_t;
    ent_t q[$];

    function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] d, input logic [4:0] a);
        case (op)
            2'b00:   return d << a;
            2'b01:   return d >> a;
            2'b10:   return 32'($signed(d) >>> a);
            default: return d;
        endcase
    endfunction

    function automatic bit m_valid();
        return q.size() > 0 && q[0].vis;
    endfunction

    function automatic bit m_in_ready();
        bit waiting;
        waiting = q.size() > 0 && !q[q.size()-1].vis;
        return !waiting || !m_valid() || bus.out_ready;
    endfunction

    task automatic drive(input bit v, input logic [1:0] op, input logic [31:0] d, input logic [31:0] rs2,
                         input logic [4:0] sh, input bit imm, input logic [4:0] tg, input bit ordy, input bit fl);
        bus.in_valid   = v;
        bus.in_op      = op;
        bus.in_data    = d;
        bus.in_rs2     = rs2;
        bus.in_shamt   = sh;
        bus.in_use_imm = imm;
        bus.in_tag     = tg;
        bus.out_ready  = ordy;
        flush          = fl;
    endtask

    task automatic tick();
        bit          acc;
        bit          pop;
        logic [4:0]  a;
        @(posedge clk);
        if (!rst_n || flush) begin
            q.delete();
        end else begin
            acc = bus.in_valid && m_in_ready();
            pop = m_valid() && bus.out_ready;
            a   = bus.in_use_imm ? bus.in_shamt : bus.in_rs2[4:0];
            if (pop) void'(q.pop_front());
            if (q.size() > 0 && !q[0].vis) q[0].vis = 1'b1;
            if (acc) q.push_back('{d: ref_res(bus.in_op, bus.in_data, a), t: bus.in_tag, vis: 1'b0});
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(0, 2'b00, 32'h0, 32'h0, 5'd0, 0, 5'd0, 0, 0);
        repeat (2) @(posedge clk);
        #2;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid got=%b want=0", bus.out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy got=%b want=0", busy); end
        checks++; if (bus.out_data !== 32'h0) begin errors++; $display("FAIL reset out_data got=%h want=0", bus.out_data); end
        checks++; if (bus.out_tag !== 5'h0 || bus.out_zero !== 1'b0) begin errors++; $display("FAIL reset out_tag/zero got=%h/%b want=0/0", bus.out_tag, bus.out_zero); end
        checks++; if (shf_in !== 32'h0 || shf_amt !== 5'h0) begin errors++; $display("FAIL reset shf got=%h/%h want=0/0", shf_in, shf_amt); end
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready got=%b want=1", bus.in_ready); end
        tick();
    endtask

    task automatic test_directed();
        logic [1:0]  ops [6] = '{2'b01, 2'b10, 2'b00, 2'b11, 2'b10, 2'b01};
        logic [31:0] dat [6] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0001, 32'h1234_5678, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] rs2 [6] = '{32'h0, 32'h0000_0024, 32'h0, 32'h0, 32'hFFFF_FFE0, 32'h0000_0021};
        logic [4:0]  sh  [6] = '{5'd31, 5'd7, 5'd31, 5'd9, 5'd5, 5'd3};
        bit          imm [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [4:0]  amt [6] = '{5'd31, 5'd4, 5'd31, 5'd9, 5'd0, 5'd1};
        logic [31:0] want[6] = '{32'h0000_0001, 32'hF800_0000, 32'h8000_0000, 32'h1234_5678, 32'h8000_0000, 32'h4000_0000};
        logic [4:0]  tg  [6] = '{5'd3, 5'd17, 5'd31, 5'd8, 5'd22, 5'd1};
        for (int unsigned i = 0; i < 6; i++) begin
            drive(1, ops[i], dat[i], rs2[i], sh[i], imm[i], tg[i], 1, 0);
            #1;
            checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL directed[%0d] in_ready got=%b want=1", i, bus.in_ready); end
            tick();
            drive(0, 2'b00, 32'h0, 32'h0, 5'd0, 0, 5'd0, 1, 0);
            #1;
            checks++; if (shf_amt !== amt[i] || bus.out_valid !== 1'b0) begin errors++; $display("FAIL directed[%0d] stage1 amt/out_valid got=%0d/%b want=%0d/0", i, shf_amt, bus.out_valid, amt[i]); end
            tick();
            checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL directed[%0d] out_valid got=%b want=1", i, bus.out_valid); end
            checks++; if (bus.out_data !== want[i]) begin errors++; $display("FAIL directed[%0d] out_data got=%h want=%h", i, bus.out_data, want[i]); end
            checks++; if (bus.out_tag !== tg[i] || bus.out_zero !== (want[i] == 32'h0)) begin errors++; $display("FAIL directed[%0d] tag/zero got=%0d/%b want=%0d/%b", i, bus.out_tag, bus.out_zero, tg[i], want[i] == 32'h0); end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        for (int unsigned i = 0; i < 10; i++) begin
            if (i < 8) drive(1, 2'b01, 32'h8000_0000 + 32'(i), 32'h0, 5'(i), 1, 5'(i), 1, 0);
            else       drive(0, 2'b00, 32'h0, 32'h0, 5'd0, 0, 5'd0, 1, 0);
            #1;
            if (i < 8) begin
                checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b[%0d] in_ready got=%b want=1", i, bus.in_ready); end
            end
            if (i >= 2) begin
                d = (32'h8000_0000 + 32'(i - 2)) >> (i - 2);
                checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL b2b[%0d] out_valid got=%b want=1", i, bus.out_valid); end
                checks++; if (bus.out_data !== d || bus.out_tag !== 5'(i - 2)) begin errors++; $display("FAIL b2b[%0d] data/tag got=%h/%0d want=%h/%0d", i, bus.out_data, bus.out_tag, d, i - 2); end
            end
            tick();
        end
        checks++; if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL b2b drained valid/busy got=%b/%b want=0/0", bus.out_valid, busy); end
    endtask

    task automatic test_backpressure();
        int unsigned acc = 0;
        for (int unsigned c = 0; c < 11; c++) begin
            drive(1, 2'b00, 32'h1111_0000 + 32'(acc), 32'h0, 5'(acc + 1), 1, 5'(acc + 10), c >= 5, 0);
            #1;
            checks++; if (bus.in_ready !== m_in_ready()) begin errors++; $display("FAIL backpressure[%0d] in_ready got=%b want=%b", c, bus.in_ready, m_in_ready()); end
            checks++; if (bus.out_valid !== m_valid()) begin errors++; $display("FAIL backpressure[%0d] out_valid got=%b want=%b", c, bus.out_valid, m_valid()); end
            if (m_valid()) begin
                checks++; if (bus.out_data !== q[0].d || bus.out_tag !== q[0].t) begin errors++; $display("FAIL backpressure[%0d] data/tag got=%h/%0d want=%h/%0d", c, bus.out_data, bus.out_tag, q[0].d, q[0].t); end
            end
            if (c == 4) begin
                checks++; if (acc != 2 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL backpressure stalled accepted/in_ready got=%0d/%b want=2/0", acc, bus.in_ready); end
            end
            if (bus.in_ready === 1'b1) acc++;
            tick();
        end
        for (int unsigned c = 0; c < 3; c++) begin
            drive(0, 2'b00, 32'h0, 32'h0, 5'd0, 0, 5'd0, 1, 0);
            #1;
            checks++; if (bus.out_valid !== m_valid()) begin errors++; $display("FAIL backpressure drain[%0d] out_valid got=%b want=%b", c, bus.out_valid, m_valid()); end
            if (m_valid()) begin
                checks++; if (bus.out_data !== q[0].d || bus.out_tag !== q[0].t) begin errors++; $display("FAIL backpressure drain[%0d] data/tag got=%h/%0d want=%h/%0d", c, bus.out_data, bus.out_tag, q[0].d, q[0].t); end
            end
            tick();
        end
    endtask

    task automatic test_flush();
        drive(1, 2'b10, 32'hC000_00F0, 32'h0, 5'd4, 1, 5'd5, 0, 0);
        tick();
        drive(1, 2'b00, 32'h0000_0F0F, 32'h0, 5'd8, 1, 5'd6, 0, 0);
        tick();
        drive(1, 2'b11, 32'hDEAD_BEEF, 32'h0, 5'd0, 1, 5'd7, 0, 1);
        #1;
        checks++; if (bus.out_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL flush full valid/busy got=%b/%b want=1/1", bus.out_valid, busy); end
        tick();
        drive(0, 2'b00, 32'h0, 32'h0, 5'd0, 0, 5'd0, 1, 0);
        #1;
        checks++; if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL flush after valid/busy got=%b/%b want=0/0", bus.out_valid, busy); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush after in_ready got=%b want=1", bus.in_ready); end
        tick();
        checks++; if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL flush op not dropped valid/busy got=%b/%b want=0/0", bus.out_valid, busy); end
    endtask

    task automatic test_random();
        logic [31:0] d;
        for (int unsigned c = 0; c < 400; c++) begin
            case ($urandom_range(0, 5))
                0:       d = 32'h0;
                1:       d = 32'h8000_0000 | $urandom;
                default: d = $urandom;
            endcase
            drive($urandom_range(0, 99) < 70, 2'($urandom), d, $urandom, 5'($urandom), 1'($urandom),
                  5'($urandom), $urandom_range(0, 99) < 65, $urandom_range(0, 99) < 3);
            #1;
            checks++; if (bus.in_ready !== m_in_ready()) begin errors++; $display("FAIL random[%0d] in_ready got=%b want=%b", c, bus.in_ready, m_in_ready()); end
            checks++; if (bus.out_valid !== m_valid() || busy !== (q.size() > 0)) begin errors++; $display("FAIL random[%0d] valid/busy got=%b/%b want=%b/%b", c, bus.out_valid, busy, m_valid(), q.size() > 0); end
            if (m_valid()) begin
                checks++;
                if (bus.out_data !== q[0].d || bus.out_tag !== q[0].t || bus.out_zero !== (q[0].d == 32'h0)) begin
                    errors++;
                    $display("FAIL random[%0d] data/tag/zero got=%h/%0d/%b want=%h/%0d/%b", c, bus.out_data, bus.out_tag, bus.out_zero, q[0].d, q[0].t, q[0].d == 32'h0);
                end
            end
            tick();
        end
        drive(0, 2'b00, 32'h0, 32'h0, 5'd0, 0, 5'd0, 1, 0);
        repeat (3) tick();
    endtask

    task automatic test_async_reset();
        drive(1, 2'b01, 32'hF0F0_F0F0, 32'h0, 5'd4, 1, 5'd9, 0, 0);
        tick();
        drive(1, 2'b00, 32'h0000_00FF, 32'h0, 5'd2, 1, 5'd11, 0, 0);
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        q.delete();
        checks++; if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL async_reset valid/busy got=%b/%b want=0/0", bus.out_valid, busy); end
        checks++; if (bus.out_data !== 32'h0 || bus.out_tag !== 5'h0 || bus.out_zero !== 1'b0) begin errors++; $display("FAIL async_reset outputs got=%h/%h/%b want=0/0/0", bus.out_data, bus.out_tag, bus.out_zero); end
        checks++; if (shf_in !== 32'h0 || shf_amt !== 5'h0) begin errors++; $display("FAIL async_reset shf got=%h/%h want=0/0", shf_in, shf_amt); end
        drive(0, 2'b00, 32'h0, 32'h0, 5'd0, 0, 5'd0, 1, 0);
        #10;
        rst_n = 1'b1;
        tick();
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL async_reset release ready/valid got=%b/%b want=1/0", bus.in_ready, bus.out_valid); end
        drive(1, 2'b10, 32'h8765_4321, 32'h0, 5'd8, 1, 5'd30, 1, 0);
        tick();
        drive(0, 2'b00, 32'h0, 32'h0, 5'd0, 0, 5'd0, 1, 0);
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hFF87_6543 || bus.out_tag !== 5'd30) begin errors++; $display("FAIL async_reset recovery valid/data/tag got=%b/%h/%0d want=1/ff876543/30", bus.out_valid, bus.out_data, bus.out_tag); end
        tick();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
